// File: rtl/alu_arb_pkg.sv
// Shared opcode constants and arbiter state encoding for the alu_arbiter block.
// Fast-path build option: ALU_ARB_FAST_PATH_EN (drops the EXEC state).
package alu_arb_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_ILL  = 3'd3;
  localparam logic [OP_W-1:0] OP_ANDN = 3'd4;
  localparam logic [OP_W-1:0] OP_ORN  = 3'd5;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd6;
  localparam logic [OP_W-1:0] OP_SLT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The illegal opcode is executed as AND with a zero B operand.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return op == OP_ILL;
  endfunction

endpackage

// File: rtl/ALU32Bit.sv
// Shared combinational ALU datapath; SLT is an unsigned compare.
module ALU32Bit
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [OP_W-1:0]       ALUControl,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      OP_AND:  ALUResult = A & B;
      OP_OR:   ALUResult = A | B;
      OP_ADD:  ALUResult = A + B;
      OP_ANDN: ALUResult = A & ~B;
      OP_ORN:  ALUResult = A | ~B;
      OP_SUB:  ALUResult = A - B;
      OP_SLT:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU32Bit between NUM_REQ valid/ready clients.
// Build option ALU_ARB_FAST_PATH_EN: ALU fed from the winner in IDLE, no EXEC state.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [OP_W*NUM_REQ-1:0]       ReqOp,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] ReqA,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] ReqB,
  output logic [NUM_REQ-1:0]            RspValid,
  input  logic [NUM_REQ-1:0]            RspReady,
  output logic [DATA_WIDTH-1:0]         RspResult,
  output logic                          RspZero,
  output logic                          Busy
);

  state_e                  state_q;
  logic [ID_W-1:0]         ptr_q;
  logic [ID_W-1:0]         ptr_d;
  logic [ID_W-1:0]         id_q;
  logic                    grant_found;
  logic [ID_W-1:0]         grant_id;
  logic [DATA_WIDTH-1:0]   rsp_result_q;
  logic                    rsp_zero_q;

  logic [OP_W-1:0]         op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   b_arr  [NUM_REQ];

  logic [OP_W-1:0]         raw_op;
  logic [DATA_WIDTH-1:0]   raw_a;
  logic [DATA_WIDTH-1:0]   raw_b;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_zero;

  // First valid requester at or above ptr, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (valid[ID_W'(idx)]) begin
        res = {1'b1, ID_W'(idx)};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = ReqOp[OP_W*g +: OP_W];
    assign a_arr[g]  = ReqA[DATA_WIDTH*g +: DATA_WIDTH];
    assign b_arr[g]  = ReqB[DATA_WIDTH*g +: DATA_WIDTH];
  end

  assign {grant_found, grant_id} = rr_pick(ReqValid, ptr_q);

  always_comb begin
    ptr_d = id_q + 1'b1;
    if (32'(id_q) == NUM_REQ - 1) begin
      ptr_d = '0;
    end
  end

`ifdef ALU_ARB_FAST_PATH_EN
  assign raw_op = op_arr[grant_id];
  assign raw_a  = a_arr[grant_id];
  assign raw_b  = b_arr[grant_id];
`else
  logic [OP_W-1:0]       op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  assign raw_op = op_q;
  assign raw_a  = a_q;
  assign raw_b  = b_q;
`endif

  assign alu_op = is_illegal_op(raw_op) ? OP_AND : raw_op;
  assign alu_b  = is_illegal_op(raw_op) ? '0 : raw_b;

  ALU32Bit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .ALUControl (alu_op),
    .A          (raw_a),
    .B          (alu_b),
    .ALUResult  (alu_result),
    .Zero       (alu_zero)
  );

  // Arbitration FSM; the response payload is held stable throughout RESP.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FAST_PATH_EN
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            id_q <= grant_id;
`ifdef ALU_ARB_FAST_PATH_EN
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            state_q      <= RESP;
`else
            op_q    <= op_arr[grant_id];
            a_q     <= a_arr[grant_id];
            b_q     <= b_arr[grant_id];
            state_q <= EXEC;
`endif
          end
        end
`ifndef ALU_ARB_FAST_PATH_EN
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          state_q      <= RESP;
        end
`endif
        RESP: begin
          if (RspReady[id_q]) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant and response strobes are decoded from state so they never overlap.
  always_comb begin
    ReqReady = '0;
    RspValid = '0;
    if (state_q == IDLE && grant_found) begin
      ReqReady[grant_id] = 1'b1;
    end
    if (state_q == RESP) begin
      RspValid[id_q] = 1'b1;
    end
  end

  assign RspResult = rsp_result_q;
  assign RspZero   = rsp_zero_q;
  assign Busy      = (state_q != IDLE);

endmodule
